// File: rtl/fifo_burst_reader.sv
// Drains fifo_single_clock into a valid/ready stream framed into fixed-length bursts.
// Define FIFO_BURST_READER_PARITY_EN to add a registered even-parity output m_parity.
module fifo_burst_reader #(
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = 8
) (
    input  logic              clk,
    input  logic              rst,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              fifo_empty,
    input  logic              flush,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
`ifdef FIFO_BURST_READER_PARITY_EN
    output logic              m_parity,
`endif
    output logic              m_last
);

    localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CW-1:0] BEAT_MAX = CW'(BURST_LEN - 1);

    logic [DATA_W-1:0] head_q;
    logic [DATA_W-1:0] head_d;
    logic [DATA_W-1:0] tail_q;
    logic [DATA_W-1:0] tail_d;
    logic [1:0]        occ_q;
    logic [1:0]        occ_d;
    logic              inflight_q;
    logic [CW-1:0]     beat_q;
    logic [CW-1:0]     beat_d;
    logic              pop;
    logic              cap;
    logic              rd_en;
    logic [2:0]        committed;

    assign pop = m_valid && m_ready;
    // A word returning during flush belongs to the dropped stream.
    assign cap = inflight_q && !flush;

    assign committed = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign rd_en     = !rst && !fifo_empty && !flush && (committed < 3'd2);

    assign fifo_rd_en = rd_en;
    assign m_valid    = (occ_q != 2'd0);
    assign m_data     = head_q;
    assign m_last     = m_valid && (beat_q == BEAT_MAX);

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        beat_d = beat_q;
        if (flush) begin
            occ_d  = 2'd0;
            beat_d = '0;
        end else begin
            unique case ({pop, cap})
                2'b11: begin
                    if (occ_q == 2'd2) begin
                        head_d = tail_q;
                        tail_d = fifo_dout;
                    end else begin
                        head_d = fifo_dout;
                    end
                end
                2'b10: begin
                    head_d = tail_q;
                    occ_d  = occ_q - 2'd1;
                end
                2'b01: begin
                    if (occ_q == 2'd0) begin
                        head_d = fifo_dout;
                    end else begin
                        tail_d = fifo_dout;
                    end
                    occ_d = occ_q + 2'd1;
                end
                default: begin
                end
            endcase
            if (pop) begin
                beat_d = (beat_q == BEAT_MAX) ? '0 : beat_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            beat_q     <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            occ_q      <= occ_d;
            inflight_q <= rd_en;
            beat_q     <= beat_d;
        end
    end

`ifdef FIFO_BURST_READER_PARITY_EN
    logic parity_q;

    // Parity follows the head register so it holds under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ^head_d;
        end
    end

    assign m_parity = parity_q;
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural model of the upstream FIFO.
// Set FIFO_BURST_READER_PARITY_EN to also exercise m_parity.
module tb_fifo_burst_reader;

    localparam int DW = 16;
    localparam int BL = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_dout = '0;
    logic          fifo_empty;
    logic          flush;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
`ifdef FIFO_BURST_READER_PARITY_EN
    logic          m_parity;
`endif

    fifo_burst_reader #(
        .DATA_W    (DW),
        .BURST_LEN (BL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .flush      (flush),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
`ifdef FIFO_BURST_READER_PARITY_EN
        .m_parity   (m_parity),
`endif
        .m_last     (m_last)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:255];
    int wptr = 0;
    int rptr = 0;

    assign fifo_empty = (rptr == wptr);

    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            fifo_dout <= mem[rptr];
            rptr      <= rptr + 1;
        end
    end

    int tests = 0;
    int fails = 0;
    int sb_ptr = 0;
    int sb_beat = 0;
    int rd_cnt = 0;
    int vcnt = 0;
    logic stall_prev = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic prev_last = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] d);
        mem[wptr] = d;
        wptr++;
    endtask

    // One clock: checks at the falling edge, returns just after the rising edge.
    task automatic cyc();
        @(negedge clk);
        if (fifo_rd_en) begin
            rd_cnt++;
            chk("rd_when_empty", {31'd0, fifo_empty}, 32'd0);
        end
        if (m_valid) vcnt++;
        if (stall_prev && !rst) begin
            chk("stall_valid", {31'd0, m_valid}, 32'd1);
            chk("stall_data", {16'd0, m_data}, {16'd0, prev_data});
            chk("stall_last", {31'd0, m_last}, {31'd0, prev_last});
        end
`ifdef FIFO_BURST_READER_PARITY_EN
        if (m_valid) chk("parity", {31'd0, m_parity}, {31'd0, ^m_data});
`endif
        if (m_valid && m_ready && !flush && !rst) begin
            chk("data", {16'd0, m_data}, {16'd0, mem[sb_ptr]});
            chk("last", {31'd0, m_last}, {31'd0, (sb_beat == BL - 1)});
            sb_ptr++;
            sb_beat = (sb_beat == BL - 1) ? 0 : sb_beat + 1;
        end
        stall_prev = m_valid && !m_ready && !flush;
        prev_data  = m_data;
        prev_last  = m_last;
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        sb_beat = 0;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        m_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_data", {16'd0, m_data}, 32'd0);
        chk("rst_last", {31'd0, m_last}, 32'd0);
        chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        rst = 1'b0;

        // Single word: exact latency and one read only
        m_ready = 1'b1;
        rd_cnt = 0;
        vcnt = 0;
        push(16'hFFFF);
        #1;
        chk("lat_rd_c0", {31'd0, fifo_rd_en}, 32'd1);
        cyc();
        chk("lat_valid_c1", {31'd0, m_valid}, 32'd0);
        cyc();
        chk("lat_valid_c2", {31'd0, m_valid}, 32'd1);
        chk("lat_data_c2", {16'd0, m_data}, 32'h0000FFFF);
        chk("lat_last_c2", {31'd0, m_last}, 32'd0);
        repeat (4) cyc();
        chk("single_rd_cnt", rd_cnt, 32'd1);
        chk("single_vcnt", vcnt, 32'd1);
        chk("single_rd_idle", {31'd0, fifo_rd_en}, 32'd0);

        // Continuous stream 0..10
        do_flush();
        m_ready = 1'b1;
        for (int i = 0; i <= 10; i++) push(16'(i));
        cyc();
        cyc();
        for (int i = 0; i < 11; i++) begin
            chk("stream_no_gap", {31'd0, m_valid}, 32'd1);
            cyc();
        end
        chk("stream_done", {31'd0, m_valid}, 32'd0);
        chk("stream_beat", {29'd0, dut.beat_q}, 32'd3);
        chk("stream_all", sb_ptr, wptr);

        // Backpressure pattern 1,0,0
        for (int i = 0; i <= 10; i++) push(16'(16'h20 + i));
        for (int i = 0; i < 45; i++) begin
            m_ready = (i % 3 == 0);
            cyc();
        end
        chk("bp_all", sb_ptr, wptr);

        // Empty gap mid-burst
        do_flush();
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) push(16'(16'h30 + i));
        repeat (10) cyc();
        chk("gap_valid", {31'd0, m_valid}, 32'd0);
        chk("gap_beat_hold", {29'd0, dut.beat_q}, 32'd5);
        repeat (5) cyc();
        for (int i = 5; i < 10; i++) push(16'(16'h30 + i));
        repeat (10) cyc();
        chk("gap_all", sb_ptr, wptr);

        // Flush with a buffered word and a read in flight
        do_flush();
        m_ready = 1'b0;
        for (int i = 0; i < 16; i++) push(16'(16'h40 + i));
        repeat (4) cyc();
        chk("fl_full_data", {16'd0, m_data}, 32'h40);
        m_ready = 1'b1;
        cyc();
        m_ready = 1'b0;
        chk("fl_head", {16'd0, m_data}, 32'h41);
        chk("fl_inflight", {31'd0, dut.inflight_q}, 32'd1);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("fl_valid_drop", {31'd0, m_valid}, 32'd0);
        sb_ptr = sb_ptr + 2;
        sb_beat = 0;
        m_ready = 1'b1;
        repeat (20) cyc();
        chk("fl_all", sb_ptr, wptr);

        // Asynchronous reset mid-burst
        do_flush();
        for (int i = 0; i < 16; i++) push(16'(16'h50 + i));
        m_ready = 1'b1;
        repeat (5) cyc();
        m_ready = 1'b0;
        repeat (3) cyc();
        chk("pre_rst_valid", {31'd0, m_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, m_valid}, 32'd0);
        chk("arst_data", {16'd0, m_data}, 32'd0);
        chk("arst_last", {31'd0, m_last}, 32'd0);
        chk("arst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        chk("arst_beat", {29'd0, dut.beat_q}, 32'd0);
        sb_ptr = rptr;
        sb_beat = 0;
        stall_prev = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("post_rst_rd", {31'd0, fifo_rd_en}, 32'd1);
        m_ready = 1'b1;
        repeat (20) cyc();
        chk("rst_all", sb_ptr, wptr);

`ifdef FIFO_BURST_READER_PARITY_EN
        m_ready = 1'b0;
        push(16'h0007);
        push(16'h0003);
        repeat (4) cyc();
        chk("par_data7", {16'd0, m_data}, 32'h7);
        chk("par_7", {31'd0, m_parity}, 32'd1);
        m_ready = 1'b1;
        cyc();
        m_ready = 1'b0;
        chk("par_data3", {16'd0, m_data}, 32'h3);
        chk("par_3", {31'd0, m_parity}, 32'd0);
        m_ready = 1'b1;
        repeat (3) cyc();
        chk("par_all", sb_ptr, wptr);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
